// File: rtl/led_pkg.sv
// led_pkg: shared definitions for LED / status output blocks.
//   led_state_t       - flash state encoding (IDLE, ON, GAP)
//   LED_*_DEF         - default parameter values for 100 MHz boards
//   cnt_width()       - counter width needed to count 0 .. max_val-1 (minimum 1)
package led_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ON   = 2'b01,
      GAP  = 2'b10
   } led_state_t;

   localparam int unsigned LED_HOLD_CYCLES_DEF = 32'd10_000_000;
   localparam int unsigned LED_GAP_CYCLES_DEF  = 32'd5_000_000;
   localparam int unsigned LED_PEND_W_DEF      = 32'd3;

   function automatic int unsigned cnt_width(input int unsigned max_val);
      if (max_val > 32'd1) begin
         return $clog2(max_val);
      end else begin
         return 32'd1;
      end
   endfunction

endpackage

// File: rtl/led_pulse_stretcher_stretch_timer.sv
// stretch_timer: cycle counter that runs while clear is low.
//   clk, reset_n - clock, asynchronous active-low reset
//   clear        - holds the count at zero
//   done         - high while count == MAX-1; the count stops there (no wrap)
module stretch_timer
   import led_pkg::*;
#(
   parameter int unsigned MAX = 32'd1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic done
);

   localparam int unsigned     W    = cnt_width(MAX);
   localparam logic [W-1:0]    LAST = W'(MAX - 32'd1);

   logic [W-1:0] count_r;

   // Count up from zero, holding at the terminal value until cleared.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (count_r != LAST) begin
         count_r <= count_r + W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign done = (count_r == LAST);

endmodule

// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher: turns short event pulses into visible LED flashes.
// Each rising edge of trigger yields one ON period of HOLD_CYCLES followed by
// an OFF gap of GAP_CYCLES; events arriving mid-flash are queued (saturating,
// up to 2^PEND_W-1) and replayed as separate flashes.
//   clk, reset_n - clock, asynchronous active-low reset
//   trigger      - event input, one event per rising edge
//   led          - stretched flash output (registered)
//   busy         - flash in progress or events queued (registered)
//   dropped      - one-cycle pulse when a queued event is lost (registered)
module led_pulse_stretcher
   import led_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = LED_HOLD_CYCLES_DEF,
   parameter int unsigned GAP_CYCLES  = LED_GAP_CYCLES_DEF,
   parameter int unsigned PEND_W      = LED_PEND_W_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic trigger,
   output logic led,
   output logic busy,
   output logic dropped
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   led_state_t        state_r;
   led_state_t        state_nxt_s;
   logic [PEND_W-1:0] pending_r;
   logic [PEND_W-1:0] pending_nxt_s;
   logic              trigger_d_r;
   logic              ev_s;
   logic              drop_s;
   logic              hold_done_s;
   logic              gap_done_s;
   logic              led_r;
   logic              busy_r;
   logic              dropped_r;

   assign ev_s = trigger & ~trigger_d_r;

   // Each timer only runs inside its own state, so it restarts from zero on entry.
   stretch_timer #(.MAX(HOLD_CYCLES)) u_hold_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state_r != ON),
      .done    (hold_done_s)
   );

   stretch_timer #(.MAX(GAP_CYCLES)) u_gap_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state_r != GAP),
      .done    (gap_done_s)
   );

   // Next-state, pending-queue and drop decision.
   always_comb begin
      state_nxt_s   = state_r;
      pending_nxt_s = pending_r;
      drop_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (ev_s) begin
               state_nxt_s = ON;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ON, GAP: begin
            // An event on the last GAP cycle is consumed directly rather than
            // queued, so it is never dropped even when the queue is full.
            if ((state_r == GAP) && gap_done_s) begin
               if (ev_s) begin
                  state_nxt_s = ON;
               end else if (pending_r != '0) begin
                  state_nxt_s   = ON;
                  pending_nxt_s = pending_r - PEND_W'(1);
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               if (ev_s && (pending_r == PEND_MAX)) begin
                  drop_s = 1'b1;
               end else if (ev_s) begin
                  pending_nxt_s = pending_r + PEND_W'(1);
               end else begin
                  pending_nxt_s = pending_r;
               end
               if ((state_r == ON) && hold_done_s) begin
                  state_nxt_s = GAP;
               end else begin
                  state_nxt_s = state_r;
               end
            end
         end
         default: begin
            state_nxt_s   = IDLE;
            pending_nxt_s = '0;
         end
      endcase
   end

   // State and outputs; led/busy come from next-state values so they line up.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         pending_r   <= '0;
         trigger_d_r <= 1'b0;
         led_r       <= 1'b0;
         busy_r      <= 1'b0;
         dropped_r   <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         pending_r   <= pending_nxt_s;
         trigger_d_r <= trigger;
         led_r       <= (state_nxt_s == ON);
         busy_r      <= (state_nxt_s != IDLE) || (pending_nxt_s != '0);
         dropped_r   <= drop_s;
      end
   end

   assign led     = led_r;
   assign busy    = busy_r;
   assign dropped = dropped_r;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// tb_led_pulse_stretcher: directed bench for led_pulse_stretcher with
// HOLD_CYCLES = 5, GAP_CYCLES = 3, PEND_W = 2. Each step drives trigger for
// one cycle and checks the registered outputs 1 time unit after the edge.
module tb_led_pulse_stretcher;

   localparam int HOLD   = 5;
   localparam int GAPC   = 3;
   localparam int PERIOD = HOLD + GAPC;

   logic clk;
   logic reset_n;
   logic trigger;
   logic led;
   logic busy;
   logic dropped;

   int n_assert;
   int n_fail;

   led_pulse_stretcher #(
      .HOLD_CYCLES (32'd5),
      .GAP_CYCLES  (32'd3),
      .PEND_W      (32'd2)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .trigger (trigger),
      .led     (led),
      .busy    (busy),
      .dropped (dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int step, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s step %0d: observed %0b expected %0b", tag, step, obs, exp);
      end
   endtask

   // Drive trig[i] on step i; expect nf back-to-back flashes starting at step 0.
   task automatic run_pattern(input string tag, input int n, input logic [63:0] trig,
                              input logic [63:0] drops, input int nf);
      logic exp_led;
      logic exp_busy;
      for (int i = 0; i < n; i++) begin
         trigger = (i < 64) ? trig[i] : 1'b0;
         @(posedge clk);
         #1;
         exp_busy = (i < PERIOD * nf);
         exp_led  = exp_busy && ((i % PERIOD) < HOLD);
         check({tag, ".led"}, i, led, exp_led);
         check({tag, ".busy"}, i, busy, exp_busy);
         check({tag, ".dropped"}, i, dropped, (i < 64) ? drops[i] : 1'b0);
      end
      trigger = 1'b0;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      trigger  = 1'b0;
      #2;
      check("reset.led", 0, led, 1'b0);
      check("reset.busy", 0, busy, 1'b0);
      check("reset.dropped", 0, dropped, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single one-cycle event: 5 high, 3 low gap, then idle.
      run_pattern("single", 12, 64'h1, 64'h0, 1);

      // Level held for 20 cycles counts as one event.
      run_pattern("held", 24, 64'hF_FFFF, 64'h0, 1);

      // Edges at steps 2, 4 (ON) and 6 (GAP) queue three extra flashes.
      run_pattern("queue3", 36, 64'h55, 64'h0, 4);

      // Edge on the final GAP cycle with nothing queued: immediate second flash.
      run_pattern("lastgap", 20, 64'h101, 64'h0, 2);

      // Saturate the queue: edges at 12 and 14 drop; edge at 16 (last GAP
      // cycle, queue full) is consumed without a drop -> six flashes.
      run_pattern("saturate", 52, 64'h1_5455, 64'h5000, 6);

      // Reset in the middle of ON with two events queued.
      run_pattern("prereset", 5, 64'h15, 64'h0, 3);
      reset_n = 1'b0;
      #1;
      check("midreset.led", 0, led, 1'b0);
      check("midreset.busy", 0, busy, 1'b0);
      check("midreset.dropped", 0, dropped, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("inreset.led", 2, led, 1'b0);
      check("inreset.busy", 2, busy, 1'b0);
      reset_n = 1'b1;
      run_pattern("postreset_quiet", 12, 64'h0, 64'h0, 0);
      run_pattern("postreset_flash", 10, 64'h1, 64'h0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
